// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and control bundles for the lab3 pipeline.
package cpu_pkg;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic cbz;
        logic ubranch;
    } ctrl_t;

    // Subset of ctrl_t that survives past EX into MEM/WB.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    always_comb count_d = (inc && count_q != '1) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk)
        if (reset) count_q <= '0;
        else       count_q <= count_d;

    assign count = count_q;
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with branch resolution, stall/flush
// and saturating taken-branch / bubble counters.
module ex_mem_reg
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_zero,
    input  logic [WIDTH-1:0]      store_data,
    input  logic [WIDTH-1:0]      branch_target,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  ctrl_mem_read,
    input  logic                  ctrl_mem_write,
    input  logic                  ctrl_reg_write,
    input  logic                  ctrl_mem_to_reg,
    input  logic                  ctrl_cbz,
    input  logic                  ctrl_ubranch,
    output logic                  mem_valid,
    output logic [WIDTH-1:0]      mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_reg_write,
    output logic                  mem_mem_to_reg,
    output logic                  branch_taken,
    output logic [WIDTH-1:0]      branch_pc,
    output logic [CNT_W-1:0]      taken_count,
    output logic [CNT_W-1:0]      bubble_count
);
    ctrl_t                 ctrl_in;
    mem_ctrl_t             mctl_q, mctl_d;
    logic                  valid_q, valid_d;
    logic [WIDTH-1:0]      addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  redirected_q, redirected_d, fresh_q, fresh_d;
    logic                  load, take, taken_inc, bubble_inc;

    always_comb begin
        ctrl_in      = '{mem_read: ctrl_mem_read, mem_write: ctrl_mem_write,
                         reg_write: ctrl_reg_write, mem_to_reg: ctrl_mem_to_reg,
                         cbz: ctrl_cbz, ubranch: ctrl_ubranch};
        load         = !flush && !stall;
        // cbz gates alu_zero first so an unknown ZERO flag on a non-CBZ op stays out.
        take         = in_valid && (ctrl_in.ubranch || (ctrl_in.cbz && alu_zero));
        valid_d      = flush ? 1'b0 : load ? in_valid : valid_q;
        mctl_d       = flush ? '0 : load ? mem_ctrl_t'({ctrl_in.mem_read, ctrl_in.mem_write,
                       ctrl_in.reg_write, ctrl_in.mem_to_reg} & {4{in_valid}}) : mctl_q;
        addr_d       = load ? alu_out : addr_q;
        wdata_d      = load ? store_data : wdata_q;
        pc_d         = load ? branch_target : pc_q;
        rd_d         = load ? rd : rd_q;
        redirected_d = (flush || load) ? (load && take) : redirected_q;
        // Marks the first resident cycle of an entry; a held entry never redirects again.
        fresh_d      = load;
        taken_inc    = load && take;
        bubble_inc   = flush || (load && !in_valid);
    end

    always_ff @(posedge clk)
        if (reset) begin
            valid_q      <= 1'b0;
            mctl_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pc_q         <= '0;
            rd_q         <= '0;
            redirected_q <= 1'b0;
            fresh_q      <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            mctl_q       <= mctl_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            rd_q         <= rd_d;
            redirected_q <= redirected_d;
            fresh_q      <= fresh_d;
        end

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk(clk), .reset(reset), .inc(taken_inc), .count(taken_count)
    );
    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk(clk), .reset(reset), .inc(bubble_inc), .count(bubble_count)
    );

    assign mem_valid      = valid_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_rd         = rd_q;
    assign mem_read       = mctl_q.mem_read;
    assign mem_write      = mctl_q.mem_write;
    assign mem_reg_write  = mctl_q.reg_write;
    assign mem_mem_to_reg = mctl_q.mem_to_reg;
    assign branch_taken   = redirected_q && fresh_q;
    assign branch_pc      = pc_q;
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: scenario tasks plus randomized run against a cycle-level
// behavioural model of the EX/MEM register (small counters to reach saturation).
module tb_ex_mem_reg;
    localparam int W  = 32;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 0, reset, stall, flush, in_valid, alu_zero;
    logic [W-1:0] alu_out, store_data, branch_target;
    logic [4:0] rd;
    logic c_rd, c_wr, c_rw, c_m2r, c_cbz, c_ub;
    logic mem_valid, mem_read, mem_write, mem_reg_write, mem_mem_to_reg, branch_taken;
    logic [W-1:0] mem_addr, mem_wdata, branch_pc;
    logic [4:0] mem_rd;
    logic [CW-1:0] taken_count, bubble_count;

    int errors = 0, checks = 0;

    logic e_valid, e_bt;
    logic [3:0] e_ctl;
    logic [W-1:0] e_addr, e_wdata, e_pc;
    logic [4:0] e_rd;
    int e_tc, e_bc;

    ex_mem_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_out(alu_out), .alu_zero(alu_zero), .store_data(store_data),
        .branch_target(branch_target), .rd(rd),
        .ctrl_mem_read(c_rd), .ctrl_mem_write(c_wr), .ctrl_reg_write(c_rw),
        .ctrl_mem_to_reg(c_m2r), .ctrl_cbz(c_cbz), .ctrl_ubranch(c_ub),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .branch_taken(branch_taken), .branch_pc(branch_pc),
        .taken_count(taken_count), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    function automatic logic [114:0] dut_vec();
        return {mem_valid, mem_addr, mem_wdata, mem_rd, mem_read, mem_write, mem_reg_write,
                mem_mem_to_reg, branch_taken, branch_pc, taken_count, bubble_count};
    endfunction

    function automatic logic [114:0] exp_vec();
        logic [CW-1:0] tc = CW'(e_tc), bc = CW'(e_bc);
        return {e_valid, e_addr, e_wdata, e_rd, e_ctl, e_bt, e_pc, tc, bc};
    endfunction

    // Reference: priority reset > flush > stall > load, counters clamp at CMAX.
    task automatic model_step();
        logic take;
        if (reset) begin
            {e_valid, e_ctl, e_bt, e_addr, e_wdata, e_pc, e_rd} = '0;
            e_tc = 0; e_bc = 0;
        end else if (flush) begin
            e_valid = 0; e_ctl = 0; e_bt = 0;
            e_bc = (e_bc < CMAX) ? e_bc + 1 : CMAX;
        end else if (stall) begin
            e_bt = 0;
        end else begin
            take = in_valid & (c_ub | (c_cbz & alu_zero));
            e_valid = in_valid;
            e_ctl = {c_rd, c_wr, c_rw, c_m2r} & {4{in_valid}};
            e_addr = alu_out; e_wdata = store_data; e_pc = branch_target; e_rd = rd;
            e_bt = take;
            if (take) e_tc = (e_tc < CMAX) ? e_tc + 1 : CMAX;
            if (!in_valid) e_bc = (e_bc < CMAX) ? e_bc + 1 : CMAX;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_in();
        reset = 0; stall = 0; flush = 0; in_valid = 0; alu_zero = 0;
        alu_out = 0; store_data = 0; branch_target = 0; rd = 0;
        {c_rd, c_wr, c_rw, c_m2r, c_cbz, c_ub} = '0;
    endtask

    task automatic do_reset();
        idle_in(); reset = 1; step(); reset = 0;
    endtask

    task automatic test_reset();
        idle_in();
        reset = 1; in_valid = 1; c_ub = 1; c_rw = 1; alu_out = 32'hdead_beef; rd = 7;
        step(); step();
        checks++;
        if (dut_vec() !== '0) begin
            errors++; $display("FAIL reset_all_zero got=%h want=0", dut_vec());
        end
        idle_in();
    endtask

    task automatic test_load();
        do_reset();
        in_valid = 1; alu_out = 32'h40; rd = 3; c_rw = 1; store_data = 32'h1234;
        step();
        checks++;
        if ({mem_valid, mem_addr, mem_rd, mem_reg_write, mem_read, mem_write} !== {1'b1, 32'h40, 5'd3, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL load got v=%b a=%h rd=%0d rw=%b want v=1 a=40 rd=3 rw=1",
                               mem_valid, mem_addr, mem_rd, mem_reg_write);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL load_model got=%h want=%h", dut_vec(), exp_vec());
        end
        idle_in();
    endtask

    task automatic test_cbz();
        do_reset();
        in_valid = 1; c_cbz = 1; alu_zero = 1; branch_target = 32'h100;
        step();
        checks++;
        if ({branch_taken, branch_pc, taken_count} !== {1'b1, 32'h100, 4'd1}) begin
            errors++; $display("FAIL cbz_taken got bt=%b pc=%h tc=%0d want bt=1 pc=100 tc=1",
                               branch_taken, branch_pc, taken_count);
        end
        idle_in(); step();
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++; $display("FAIL cbz_pulse got bt=%b want 0", branch_taken);
        end
        in_valid = 1; c_cbz = 1; alu_zero = 0; branch_target = 32'h100;
        step();
        checks++;
        if ({branch_taken, taken_count} !== {1'b0, 4'd1}) begin
            errors++; $display("FAIL cbz_not_taken got bt=%b tc=%0d want bt=0 tc=1", branch_taken, taken_count);
        end
        idle_in();
    endtask

    task automatic test_stall_after_branch();
        do_reset();
        in_valid = 1; c_ub = 1; branch_target = 32'h200;
        step();
        checks++;
        if ({branch_taken, mem_valid, taken_count} !== {1'b1, 1'b1, 4'd1}) begin
            errors++; $display("FAIL ub_load got bt=%b v=%b tc=%0d want bt=1 v=1 tc=1",
                               branch_taken, mem_valid, taken_count);
        end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({branch_taken, mem_valid, taken_count, branch_pc} !== {1'b0, 1'b1, 4'd1, 32'h200}) begin
                errors++; $display("FAIL stall_hold[%0d] got bt=%b v=%b tc=%0d pc=%h want bt=0 v=1 tc=1 pc=200",
                                   i, branch_taken, mem_valid, taken_count, branch_pc);
            end
        end
        stall = 0; in_valid = 0; c_ub = 0;
        step();
        checks++;
        if (branch_taken !== 1'b0) begin
            errors++; $display("FAIL post_stall_bt got=%b want 0", branch_taken);
        end
        idle_in();
    endtask

    task automatic test_flush_vs_stall();
        do_reset();
        in_valid = 1; c_wr = 1; alu_out = 32'h55; store_data = 32'h99;
        step();
        idle_in(); flush = 1; stall = 1; in_valid = 1; alu_out = 32'h77;
        step();
        checks++;
        if ({mem_valid, mem_write, mem_addr, mem_wdata, bubble_count} !== {1'b0, 1'b0, 32'h55, 32'h99, 4'd1}) begin
            errors++; $display("FAIL flush_stall got v=%b w=%b a=%h d=%h bc=%0d want v=0 w=0 a=55 d=99 bc=1",
                               mem_valid, mem_write, mem_addr, mem_wdata, bubble_count);
        end
        idle_in();
    endtask

    task automatic test_bubble();
        do_reset();
        in_valid = 0; {c_rd, c_wr, c_rw, c_m2r, c_cbz, c_ub} = '1; alu_zero = 1;
        step();
        checks++;
        if ({mem_valid, mem_read, mem_write, mem_reg_write, mem_mem_to_reg, branch_taken, taken_count, bubble_count}
            !== {6'b0, 4'd0, 4'd1}) begin
            errors++; $display("FAIL bubble got ctl=%b%b%b%b%b%b tc=%0d bc=%0d want ctl=000000 tc=0 bc=1",
                               mem_valid, mem_read, mem_write, mem_reg_write, mem_mem_to_reg, branch_taken,
                               taken_count, bubble_count);
        end
        idle_in();
    endtask

    task automatic test_x_zero();
        do_reset();
        in_valid = 1; c_cbz = 0; c_ub = 0; alu_zero = 1'bx; c_rw = 1;
        step();
        checks++;
        if (dut_vec() !== exp_vec() || branch_taken !== 1'b0) begin
            errors++; $display("FAIL x_zero got=%h want=%h", dut_vec(), exp_vec());
        end
        idle_in();
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1; c_ub = 1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (taken_count !== 4'(CMAX)) begin
            errors++; $display("FAIL sat_taken got=%0d want=%0d", taken_count, CMAX);
        end
        idle_in();
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bubble_count !== 4'(CMAX)) begin
            errors++; $display("FAIL sat_bubble got=%0d want=%0d", bubble_count, CMAX);
        end
        reset = 1; step(); reset = 0;
        checks++;
        if ({taken_count, bubble_count} !== 8'h0) begin
            errors++; $display("FAIL sat_reset got tc=%0d bc=%0d want 0 0", taken_count, bubble_count);
        end
        idle_in();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            alu_zero = 1'($urandom);
            alu_out = $urandom; store_data = $urandom; branch_target = $urandom;
            rd = 5'($urandom);
            {c_rd, c_wr, c_rw, c_m2r, c_cbz, c_ub} = 6'($urandom);
            step();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d] got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
        idle_in();
    endtask

    initial begin
        idle_in();
        e_tc = 0; e_bc = 0;
        test_reset();
        test_load();
        test_cbz();
        test_stall_after_branch();
        test_flush_vs_stall();
        test_bubble();
        test_x_zero();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register for the lab3 datapath. It sits directly downstream of the ALU and captures the 32-bit result and ZERO flag together with the memory/writeback control bits. It resolves CBZ/unconditional branches and presents a one-cycle redirect to fetch. It supports stall and flush from the hazard unit, and keeps saturating counters of taken branches and inserted bubbles for the lab performance report.

## Interface

Parameters:
- `WIDTH`, 32, datapath width (ALU result, store data, branch target).
- `CNT_W`, 16, width of each performance counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  hold all stage contents this cycle.
- `flush`  in  1  replace stage contents with a bubble this cycle.
- `in_valid`  in  1  EX stage holds a real instruction.
- `alu_out`  in  WIDTH  ALU result (memory address or writeback value).
- `alu_zero`  in  1  ALU ZERO flag.
- `store_data`  in  WIDTH  register value for STUR.
- `branch_target`  in  WIDTH  PC + offset computed in EX.
- `rd`  in  5  destination register.
- `ctrl_mem_read`, `ctrl_mem_write`, `ctrl_reg_write`, `ctrl_mem_to_reg`, `ctrl_cbz`, `ctrl_ubranch`  in  1 each  decoded control.
- `mem_valid`  out  1  stage holds a real instruction.
- `mem_addr`  out  WIDTH  registered `alu_out`.
- `mem_wdata`  out  WIDTH  registered `store_data`.
- `mem_rd`  out  5  registered `rd`.
- `mem_read`, `mem_write`, `mem_reg_write`, `mem_mem_to_reg`  out  1 each  registered control, gated by valid.
- `branch_taken`  out  1  redirect fetch this cycle.
- `branch_pc`  out  WIDTH  registered `branch_target`.
- `taken_count`  out  CNT_W  saturating count of taken branches.
- `bubble_count`  out  CNT_W  saturating count of bubbles loaded.

## Operation

- Priority per cycle: `reset` > `flush` > `stall` > load.
- Reset: all outputs and internal state go to 0, including `mem_valid`, the control outputs, `branch_taken`, data fields and both counters.
- Flush: `mem_valid` and all control bits go to 0. Data fields hold their previous values. `branch_taken` goes to 0. `bubble_count` increments.
- Stall without flush: every register holds. `branch_taken` is forced to 0 during the stall (see the `redirected` rule below). Counters hold.
- Load: capture all inputs. Controls are stored as `ctrl_* & in_valid`. If `in_valid`=0, `bubble_count` increments.
- Branch decision, computed at load: `take = in_valid & (ctrl_ubranch | (ctrl_cbz & alu_zero))`.
  - `branch_taken` = `take` for exactly the first cycle the entry is resident.
  - Internal `redirected` flag: set on load when `take`=1, cleared on any other load, flush or reset.
  - While stalled, `branch_taken` = 0, so a held entry never redirects twice.
- `taken_count` increments on each load with `take`=1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `alu_zero` is trusted only when `ctrl_cbz`=1. An X on `alu_zero` with `ctrl_cbz`=0 must not affect any output.

## Timing

- Latency is 1 cycle: inputs sampled at edge N appear at the outputs after edge N. All outputs are registered; there is no combinational input-to-output path.
- `branch_taken` is a single-cycle pulse per branch regardless of subsequent stalls.
- `flush` and `stall` together: flush wins, and the bubble is counted.
- `reset` asserted mid-stall or mid-branch: next cycle all outputs are 0 and `redirected` is cleared.
- Counter at max with another event: holds at max.

## Structure

- Shared package `cpu_pkg`:
  - `ctrl_t` packed struct holding the six control bits, shared with decode and the ALU-control stage.
  - `DATA_W` = 32.
  - `REG_ADDR_W` = 5.
- One natural sub-module: `sat_counter` (parameterised width, `inc` input, sync reset), instantiated twice.
- Remaining logic is flat in `ex_mem_reg`.

## Test plan

- Reset then load: reset 2 cycles, then load `alu_out`=0x0000_0040, `rd`=3, `ctrl_reg_write`=1, `in_valid`=1. Expect `mem_addr`=0x40, `mem_rd`=3, `mem_reg_write`=1, `mem_valid`=1 one cycle later, and all outputs 0 during reset.
- CBZ taken: `ctrl_cbz`=1, `alu_zero`=1, `branch_target`=0x100. Expect `branch_taken`=1 for one cycle, `branch_pc`=0x100, `taken_count`=1. Repeat with `alu_zero`=0: expect `branch_taken`=0 and the count unchanged.
- Stall after taken branch: load a `ctrl_ubranch` entry, then hold `stall` for 3 cycles. Expect `branch_taken` high only in the first cycle, `mem_valid` held at 1, `taken_count`=1.
- Flush vs stall: assert `flush` and `stall` together on a valid entry with `ctrl_mem_write`=1. Expect `mem_valid`=0, `mem_write`=0, `mem_addr` unchanged, `bubble_count`+1.
- Bubble via `in_valid`=0 with all ctrl inputs at 1: expect all mem control outputs 0, `branch_taken`=0, `bubble_count`+1.
- Saturation: with `CNT_W`=4, issue 20 taken branches. Expect `taken_count` stuck at 15. Then assert reset: expect 0.
